// File: rtl/port_pkg.sv
// port_pkg: lock-port types shared by the switch-side port FSM, the lock
// controller and the door-side port_actuator.
//   port_state_e : gate state encoding (CLOSED, OPENING, OPEN, CLOSING)
package port_pkg;

   typedef enum logic [1:0] {
      CLOSED  = 2'b00,
      OPENING = 2'b01,
      OPEN    = 2'b10,
      CLOSING = 2'b11
   } port_state_e;

endpackage : port_pkg

// File: rtl/port_actuator_if.sv
// port_actuator_if: command/status bundle between the lock controller and
// the door-side gate actuator.
//   OpenReq   : command level, 1 = gate should be open
//   Interlock : 1 = opening permitted (water levels equalised)
//   Position  : 0 = fully closed, TRAVEL_CYCLES = fully open
//   IsClosed / IsOpen / Moving : registered state decode
//   Done      : one-cycle pulse on arrival at either end stop
//   Trip      : one-cycle pulse when an opening is aborted by Interlock low
// modport master : controller side (drives command, reads status)
// modport slave  : actuator side
interface port_actuator_if #(
   parameter int unsigned TRAVEL_CYCLES = 8
);
   localparam int unsigned POS_W = $clog2(TRAVEL_CYCLES + 1);

   logic             OpenReq;
   logic             Interlock;
   logic [POS_W-1:0] Position;
   logic             IsClosed;
   logic             IsOpen;
   logic             Moving;
   logic             Done;
   logic             Trip;

   modport master (
      output OpenReq, Interlock,
      input  Position, IsClosed, IsOpen, Moving, Done, Trip
   );

   modport slave (
      input  OpenReq, Interlock,
      output Position, IsClosed, IsOpen, Moving, Done, Trip
   );

endinterface : port_actuator_if

// File: rtl/port_travel_counter.sv
// port_travel_counter: saturating up/down gate-position counter with hold.
//   clk, rst : clock, synchronous active-high reset (count -> 0)
//   inc, dec : step up / down by one (inc wins if both are set)
//   count    : current position, 0..TRAVEL_CYCLES
//   at_zero  : count == 0
//   at_max   : count == TRAVEL_CYCLES
module port_travel_counter #(
   parameter int unsigned TRAVEL_CYCLES = 8
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               inc,
   input  logic                               dec,
   output logic [$clog2(TRAVEL_CYCLES+1)-1:0] count,
   output logic                               at_zero,
   output logic                               at_max
);
   localparam int unsigned       POS_W   = $clog2(TRAVEL_CYCLES + 1);
   localparam logic [POS_W-1:0]  MAX_POS = POS_W'(TRAVEL_CYCLES);

   logic [POS_W-1:0] count_q, count_d;

   assign at_zero = (count_q == '0);
   assign at_max  = (count_q == MAX_POS);
   assign count   = count_q;

   always_comb begin
      count_d = count_q;
      if (inc && !at_max) begin
         count_d = count_q + POS_W'(1);
      end else if (dec && !inc && !at_zero) begin
         count_d = count_q - POS_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule : port_travel_counter

// File: rtl/port_actuator.sv
// port_actuator: door-side responder for the lock port command. Models a gate
// that needs TRAVEL_CYCLES clock edges to travel between end stops, enforces
// the water-level interlock on opening and reverses mid-travel on command
// change. All status outputs are registered.
//   Clock : system clock, rising edge
//   Reset : synchronous, active-high
//   port  : port_actuator_if slave (OpenReq, Interlock in; Position,
//           IsClosed, IsOpen, Moving, Done, Trip out)
module port_actuator
   import port_pkg::*;
#(
   parameter int unsigned TRAVEL_CYCLES = 8
) (
   input  logic             Clock,
   input  logic             Reset,
   port_actuator_if.slave   port
);
   localparam int unsigned      POS_W     = $clog2(TRAVEL_CYCLES + 1);
   localparam logic [POS_W-1:0] LAST_STEP = POS_W'(TRAVEL_CYCLES - 1);
   localparam logic [POS_W-1:0] ONE       = POS_W'(1);

   port_state_e      state_q, state_d;
   logic             is_closed_q, is_closed_d;
   logic             is_open_q, is_open_d;
   logic             moving_q, moving_d;
   logic             done_q, done_d;
   logic             trip_q, trip_d;

   logic             cnt_inc, cnt_dec;
   logic [POS_W-1:0] pos;
   logic             at_zero, at_max;

   port_travel_counter #(
      .TRAVEL_CYCLES (TRAVEL_CYCLES)
   ) u_travel (
      .clk     (Clock),
      .rst     (Reset),
      .inc     (cnt_inc),
      .dec     (cnt_dec),
      .count   (pos),
      .at_zero (at_zero),
      .at_max  (at_max)
   );

   // Arrival is judged on the post-step value. A direction flip can leave the
   // gate travelling while already at an end stop (e.g. OPENING aborted at 0);
   // the saturating counter holds there and the arrival still fires.
   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      trip_d  = 1'b0;
      cnt_inc = 1'b0;
      cnt_dec = 1'b0;
      unique case (state_q)
         CLOSED: begin
            if (port.OpenReq && port.Interlock) begin
               state_d = OPENING;
            end
         end
         OPENING: begin
            if (!port.OpenReq) begin
               state_d = CLOSING;
            end else if (!port.Interlock) begin
               state_d = CLOSING;
               trip_d  = 1'b1;
            end else begin
               cnt_inc = 1'b1;
               if (at_max || pos == LAST_STEP) begin
                  state_d = OPEN;
                  done_d  = 1'b1;
               end
            end
         end
         OPEN: begin
            if (!port.OpenReq) begin
               state_d = CLOSING;
            end
         end
         CLOSING: begin
            if (port.OpenReq && port.Interlock) begin
               state_d = OPENING;
            end else begin
               cnt_dec = 1'b1;
               if (at_zero || pos == ONE) begin
                  state_d = CLOSED;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = CLOSED;
         end
      endcase

      is_closed_d = (state_d == CLOSED);
      is_open_d   = (state_d == OPEN);
      moving_d    = (state_d == OPENING) || (state_d == CLOSING);
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q     <= CLOSED;
         is_closed_q <= 1'b1;
         is_open_q   <= 1'b0;
         moving_q    <= 1'b0;
         done_q      <= 1'b0;
         trip_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         is_closed_q <= is_closed_d;
         is_open_q   <= is_open_d;
         moving_q    <= moving_d;
         done_q      <= done_d;
         trip_q      <= trip_d;
      end
   end

   assign port.Position = pos;
   assign port.IsClosed = is_closed_q;
   assign port.IsOpen   = is_open_q;
   assign port.Moving   = moving_q;
   assign port.Done     = done_q;
   assign port.Trip     = trip_q;

endmodule : port_actuator

// File: tb/tb_port_actuator.sv
// tb_port_actuator: directed-vector bench for port_actuator, TRAVEL_CYCLES=8.
module tb_port_actuator;

   localparam int unsigned T = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   port_actuator_if #(.TRAVEL_CYCLES(T)) pif ();

   port_actuator #(
      .TRAVEL_CYCLES (T)
   ) dut (
      .Clock (clk),
      .Reset (rst),
      .port  (pif)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      n_checks++;
      if (observed === expected) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // One active edge, then settle before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Status packed as {Position[3:0], IsClosed, IsOpen, Moving, Done, Trip}.
   task automatic expect_st(input string tag, input int p, input bit c,
                            input bit o, input bit m, input bit d, input bit t);
      logic [8:0] obs;
      logic [8:0] exp_v;
      obs   = {pif.Position, pif.IsClosed, pif.IsOpen, pif.Moving, pif.Done, pif.Trip};
      exp_v = {4'(p), c, o, m, d, t};
      check(tag, 32'(obs), 32'(exp_v));
   endtask

   // Step and expect a travelling gate (no pulses) at each position lo..hi / hi..lo.
   task automatic travel(input string tag, input int from, input int to);
      int p;
      p = from;
      while (p != to) begin
         p = (to > from) ? p + 1 : p - 1;
         step();
         expect_st($sformatf("%s_p%0d", tag, p), p, 0, 0, 1, 0, 0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "timeout");
   end

   initial begin
      pif.OpenReq   = 1'b0;
      pif.Interlock = 1'b0;

      // Reset
      rst = 1'b1;
      step();
      step();
      expect_st("reset", 0, 1, 0, 0, 0, 0);
      rst = 1'b0;
      step();
      expect_st("idle", 0, 1, 0, 0, 0, 0);

      // Full open then full close
      pif.OpenReq = 1'b1; pif.Interlock = 1'b1;
      step();
      expect_st("open_req", 0, 0, 0, 1, 0, 0);
      travel("open", 0, 7);
      step();
      expect_st("open_arrive", 8, 0, 1, 0, 1, 0);
      step();
      expect_st("open_hold", 8, 0, 1, 0, 0, 0);
      pif.OpenReq = 1'b0;
      step();
      expect_st("close_req", 8, 0, 0, 1, 0, 0);
      travel("close", 8, 1);
      step();
      expect_st("close_arrive", 0, 1, 0, 0, 1, 0);
      step();
      expect_st("close_hold", 0, 1, 0, 0, 0, 0);

      // Interlock trip at position 3
      pif.OpenReq = 1'b1; pif.Interlock = 1'b1;
      step();
      expect_st("trip_req", 0, 0, 0, 1, 0, 0);
      travel("trip_open", 0, 3);
      pif.Interlock = 1'b0;
      step();
      expect_st("trip_pulse", 3, 0, 0, 1, 0, 1);
      travel("trip_back", 3, 1);
      step();
      expect_st("trip_closed", 0, 1, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) begin
         step();
         expect_st($sformatf("trip_rest%0d", i), 0, 1, 0, 0, 0, 0);
      end

      // Open, close to 5, reverse back to OPEN
      pif.Interlock = 1'b1;
      step();
      travel("rev_open", 0, 7);
      step();
      expect_st("rev_open_arrive", 8, 0, 1, 0, 1, 0);
      pif.OpenReq = 1'b0;
      step();
      expect_st("rev_close_req", 8, 0, 0, 1, 0, 0);
      travel("rev_close", 8, 5);
      pif.OpenReq = 1'b1;
      step();
      expect_st("rev_hold5", 5, 0, 0, 1, 0, 0);
      travel("rev_reopen", 5, 7);
      step();
      expect_st("rev_arrive", 8, 0, 1, 0, 1, 0);

      // Interlock loss while OPEN is ignored
      pif.Interlock = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         expect_st($sformatf("open_noilk%0d", i), 8, 0, 1, 0, 0, 0);
      end
      pif.OpenReq = 1'b0;
      step();
      expect_st("noilk_close_req", 8, 0, 0, 1, 0, 0);
      travel("noilk_close", 8, 1);
      step();
      expect_st("noilk_closed", 0, 1, 0, 0, 1, 0);

      // Reset mid-travel at position 4
      pif.OpenReq = 1'b1; pif.Interlock = 1'b1;
      step();
      travel("rst_open", 0, 4);
      rst = 1'b1;
      step();
      expect_st("rst_mid", 0, 1, 0, 0, 0, 0);
      rst = 1'b0;
      step();
      expect_st("rst_reopen_req", 0, 0, 0, 1, 0, 0);
      travel("rst_reopen", 0, 7);
      step();
      expect_st("rst_reopen_arrive", 8, 0, 1, 0, 1, 0);

      // Close, then wait in CLOSED with Interlock low
      pif.OpenReq = 1'b0;
      for (int i = 0; i < 9; i++) step();
      expect_st("wait_closed", 0, 1, 0, 0, 1, 0);
      pif.OpenReq = 1'b1; pif.Interlock = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         expect_st($sformatf("wait_ilk%0d", i), 0, 1, 0, 0, 0, 0);
      end
      pif.Interlock = 1'b1;
      step();
      expect_st("ilk_rise", 0, 0, 0, 1, 0, 0);
      step();
      expect_st("ilk_p1", 1, 0, 0, 1, 0, 0);

      // Reversal at position 1, and at position 0
      pif.OpenReq = 1'b0;
      step();
      expect_st("rev1_hold", 1, 0, 0, 1, 0, 0);
      step();
      expect_st("rev1_closed", 0, 1, 0, 0, 1, 0);
      pif.OpenReq = 1'b1;
      step();
      expect_st("rev0_req", 0, 0, 0, 1, 0, 0);
      pif.OpenReq = 1'b0;
      step();
      expect_st("rev0_hold", 0, 0, 0, 1, 0, 0);
      step();
      expect_st("rev0_closed", 0, 1, 0, 0, 1, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_port_actuator
